// File: rtl/sdram_req_frontend.sv
// sdram_req_frontend: write FIFO plus single read slot, arbitrated onto the sdram_controller req/ack interface.
// Define SDRAM_RAW_ORDER_EN to hold a read back until every earlier-queued write has been issued.
module sdram_req_frontend #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 16,
    parameter int FIFO_AW = 3
) (
    input  logic               iclk,
    input  logic               ireset_n,
    input  logic               iwr_valid,
    output logic               owr_ready,
    input  logic [ADDR_W-1:0]  iwr_address,
    input  logic [DATA_W-1:0]  iwr_data,
    input  logic               ird_valid,
    output logic               ord_ready,
    input  logic [ADDR_W-1:0]  ird_address,
    output logic [DATA_W-1:0]  ord_data,
    output logic               ord_data_valid,
    output logic [FIFO_AW:0]   ofifo_level,
    output logic               owrite_req,
    output logic [ADDR_W-1:0]  owrite_address,
    output logic [DATA_W-1:0]  owrite_data,
    input  logic               iwrite_ack,
    output logic               oread_req,
    output logic [ADDR_W-1:0]  oread_address,
    input  logic [DATA_W-1:0]  iread_data,
    input  logic               iread_ack
);
    localparam int DEPTH = 2 ** FIFO_AW;
    typedef enum logic [1:0] {IDLE, WR, RD, GAP} state_t;
    state_t                    state_q, state_d;
    logic [ADDR_W+DATA_W-1:0]  mem_q [DEPTH];
    logic [ADDR_W+DATA_W-1:0]  head;
    logic [FIFO_AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]          level_q, level_d;
    logic                      rd_pending_q, rd_pending_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]         rd_data_q, rd_data_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      last_rd_q, last_rd_d;
    logic                      full, empty, push, pop, rd_take, rd_done, wr_ok, rd_ok, grant_wr;

    // level never exceeds DEPTH, so its top bit alone means full
    assign full     = level_q[FIFO_AW];
    assign empty    = level_q == '0;
    assign push     = iwr_valid && !full;
    assign pop      = state_q == WR && iwrite_ack;
    assign rd_take  = ird_valid && !rd_pending_q;
    assign rd_done  = state_q == RD && iread_ack;
    assign wr_ok    = !empty;
`ifdef SDRAM_RAW_ORDER_EN
    assign rd_ok    = rd_pending_q && empty && state_q != WR;
`else
    assign rd_ok    = rd_pending_q;
`endif
    assign grant_wr = wr_ok && (!rd_ok || last_rd_q);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d     = rd_ptr_q + FIFO_AW'(pop);
        level_d      = level_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        rd_pending_d = rd_take ? 1'b1 : (rd_done ? 1'b0 : rd_pending_q);
        rd_addr_d    = rd_take ? ird_address : rd_addr_q;
        rd_data_d    = rd_done ? iread_data : rd_data_q;
        rd_valid_d   = rd_done;
    end

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        case (state_q)
            IDLE: if (wr_ok || rd_ok) begin
                state_d   = grant_wr ? WR : RD;
                last_rd_d = !grant_wr;
            end
            WR:      state_d = iwrite_ack ? GAP : WR;
            RD:      state_d = iread_ack ? GAP : RD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            rd_pending_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            last_rd_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            rd_pending_q <= rd_pending_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            last_rd_q    <= last_rd_d;
        end
    end

    always_ff @(posedge iclk) begin
        if (push) mem_q[wr_ptr_q] <= {iwr_address, iwr_data};
    end

    assign owr_ready      = !full;
    assign ord_ready      = !rd_pending_q;
    assign ord_data       = rd_data_q;
    assign ord_data_valid = rd_valid_q;
    assign ofifo_level    = level_q;
    assign owrite_req     = state_q == WR;
    assign owrite_address = owrite_req ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign owrite_data    = owrite_req ? head[DATA_W-1:0] : '0;
    assign oread_req      = state_q == RD;
    assign oread_address  = oread_req ? rd_addr_q : '0;
endmodule

// File: tb/tb_sdram_req_frontend.sv
// tb_sdram_req_frontend: directed stimulus with a queue-based reference model and an acking controller model.
// Honours SDRAM_RAW_ORDER_EN the same way the design does.
module tb_sdram_req_frontend;
    logic        iclk, ireset_n;
    logic        iwr_valid, owr_ready, ird_valid, ord_ready, ord_data_valid;
    logic [21:0] iwr_address, ird_address, owrite_address, oread_address;
    logic [15:0] iwr_data, ord_data, owrite_data, iread_data;
    logic [3:0]  ofifo_level;
    logic        owrite_req, iwrite_ack, oread_req, iread_ack;

    sdram_req_frontend dut (
        .iclk(iclk), .ireset_n(ireset_n),
        .iwr_valid(iwr_valid), .owr_ready(owr_ready), .iwr_address(iwr_address), .iwr_data(iwr_data),
        .ird_valid(ird_valid), .ord_ready(ord_ready), .ird_address(ird_address),
        .ord_data(ord_data), .ord_data_valid(ord_data_valid), .ofifo_level(ofifo_level),
        .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
        .iwrite_ack(iwrite_ack), .oread_req(oread_req), .oread_address(oread_address),
        .iread_data(iread_data), .iread_ack(iread_ack)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Controller model: acks after dly cycles of req, keeps a word store
    bit          auto_en = 1'b1, spur_w = 1'b0, spur_r = 1'b0;
    int          dly = 1, wc = 0, rc = 0, wacks = 0;
    logic [15:0] sdram [logic [21:0]];

    always @(negedge iclk) begin
        iwrite_ack = spur_w;
        iread_ack  = spur_r;
        if (spur_r) iread_data = 16'hDEAD;
        if (!ireset_n) begin
            wc = 0;
            rc = 0;
        end else if (auto_en) begin
            if (owrite_req) begin
                wc++;
                if (wc >= dly) begin
                    iwrite_ack = 1'b1;
                    sdram[owrite_address] = owrite_data;
                    wc = 0;
                    wacks++;
                end
            end else wc = 0;
            if (oread_req) begin
                rc++;
                if (rc >= dly) begin
                    iread_ack  = 1'b1;
                    iread_data = sdram.exists(oread_address) ? sdram[oread_address] : 16'h0000;
                    rc = 0;
                end
            end else rc = 0;
        end
    end

    // Reference model: queue of pending writes, one read slot, which command is in flight
    logic [37:0] mq[$];
    bit          pend, gap, last_r, exp_v, m_push, m_acc, wok, rok;
    logic [21:0] raddr;
    logic [15:0] exp_rdata;
    int          cur, sz;

    always @(posedge iclk) begin
        if (!ireset_n) begin
            mq.delete();
            pend = 0; cur = 0; gap = 0; last_r = 1; exp_v = 0; exp_rdata = '0; raddr = '0;
        end else begin
            sz     = mq.size();
            m_push = iwr_valid && sz < 8;
            m_acc  = ird_valid && !pend;
            wok    = sz > 0;
`ifdef SDRAM_RAW_ORDER_EN
            rok    = pend && sz == 0;
`else
            rok    = pend;
`endif
            exp_v  = 0;
            if (cur == 1 && iwrite_ack) begin
                void'(mq.pop_front());
                cur = 0; gap = 1;
            end else if (cur == 2 && iread_ack) begin
                exp_rdata = iread_data; exp_v = 1; pend = 0; cur = 0; gap = 1;
            end else if (gap) gap = 0;
            else if (cur == 0 && (wok || rok)) begin
                cur    = (wok && rok) ? (last_r ? 1 : 2) : (wok ? 1 : 2);
                last_r = cur == 2;
            end
            if (m_push) mq.push_back({iwr_address, iwr_data});
            if (m_acc) begin
                pend = 1; raddr = ird_address;
            end
        end
        #1;
        chk("m_level", 64'(ofifo_level), 64'(mq.size()));
        chk("m_wr_ready", 64'(owr_ready), 64'(mq.size() < 8));
        chk("m_rd_ready", 64'(ord_ready), 64'(!pend));
        chk("m_write_req", 64'(owrite_req), 64'(cur == 1));
        chk("m_read_req", 64'(oread_req), 64'(cur == 2));
        chk("m_rd_valid", 64'(ord_data_valid), 64'(exp_v));
        chk("m_rd_data", 64'(ord_data), 64'(exp_rdata));
        if (cur == 1 && mq.size() > 0) chk("m_write_head", {26'd0, owrite_address, owrite_data}, 64'(mq[0]));
        if (cur == 2) chk("m_read_addr", 64'(oread_address), 64'(raddr));
    end

    int grants[$];
    bit pw = 0, pr = 0;
    always @(posedge iclk) begin
        #2;
        if (owrite_req && !pw) grants.push_back(1);
        if (oread_req && !pr) grants.push_back(2);
        pw = owrite_req;
        pr = oread_req;
    end

    task automatic wr(input logic [21:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge iclk);
        iwr_valid = 1; iwr_address = a; iwr_data = d;
        while (!owr_ready && n < 200) begin
            @(negedge iclk);
            n++;
        end
        if (n >= 200) chk("wr_timeout", 0, 1);
        @(negedge iclk);
        iwr_valid = 0;
    endtask

    task automatic rd(input logic [21:0] a);
        int n = 0;
        @(negedge iclk);
        ird_valid = 1; ird_address = a;
        while (!ord_ready && n < 200) begin
            @(negedge iclk);
            n++;
        end
        if (n >= 200) chk("rd_timeout", 0, 1);
        @(negedge iclk);
        ird_valid = 0;
    endtask

    task automatic settle();
        int n = 0;
        while ((ofifo_level != 0 || owrite_req || oread_req || !ord_ready) && n < 300) begin
            @(negedge iclk);
            n++;
        end
        if (n >= 300) chk("settle_timeout", 0, 1);
        repeat (3) @(negedge iclk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0;
        ireset_n = 0; iwr_valid = 0; ird_valid = 0;
        iwr_address = '0; iwr_data = '0; ird_address = '0; iread_data = '0;
        repeat (3) @(negedge iclk);
        ireset_n = 1;
        @(negedge iclk);
        chk("rst_wr_ready", 64'(owr_ready), 1);
        chk("rst_rd_ready", 64'(ord_ready), 1);
        chk("rst_level", 64'(ofifo_level), 0);
        chk("rst_reqs", {62'd0, owrite_req, oread_req}, 0);

        // single write with a slow ack
        dly = 5;
        wr(22'd0, 16'd19);
        chk("t2_level_after_push", 64'(ofifo_level), 1);
        chk("t2_req_not_yet", 64'(owrite_req), 0);
        @(negedge iclk);
        chk("t2_req_rise", 64'(owrite_req), 1);
        n = 0;
        while (owrite_req && n < 50) begin
            chk("t2_addr", 64'(owrite_address), 0);
            chk("t2_data", 64'(owrite_data), 19);
            @(negedge iclk);
            n++;
        end
        chk("t2_req_cycles", 64'(n), 5);
        chk("t2_level_after_ack", 64'(ofifo_level), 0);
        dly = 1;
        settle();

        // reset while a write is being requested
        auto_en = 0;
        wr(22'd5, 16'd7);
        @(negedge iclk);
        chk("t1_req_before_rst", 64'(owrite_req), 1);
        ireset_n = 0;
        #1;
        chk("t1_req_dropped", 64'(owrite_req), 0);
        chk("t1_level", 64'(ofifo_level), 0);
        chk("t1_wr_ready", 64'(owr_ready), 1);
        chk("t1_rd_ready", 64'(ord_ready), 1);
        @(negedge iclk);
        ireset_n = 1;
        auto_en = 1;
        settle();

        // fill the FIFO with no acks, ninth write waits for a pop
        auto_en = 0;
        w0 = wacks;
        for (int i = 0; i < 8; i++) wr(22'(i + 32), 16'(16'h0100 + i));
        chk("t3_level_full", 64'(ofifo_level), 8);
        chk("t3_not_ready", 64'(owr_ready), 0);
        @(negedge iclk);
        iwr_valid = 1; iwr_address = 22'd40; iwr_data = 16'h0109;
        repeat (3) @(negedge iclk);
        chk("t3_ninth_held", 64'(ofifo_level), 8);
        auto_en = 1;
        n = 0;
        while (!owr_ready && n < 50) begin
            @(negedge iclk);
            n++;
        end
        chk("t3_ready_again", 64'(owr_ready), 1);
        @(negedge iclk);
        iwr_valid = 0;
        settle();
        chk("t3_acks", 64'(wacks - w0), 9);

        // spurious acks: read ack during a write, write ack while idle
        auto_en = 0;
        wr(22'h55, 16'hAAAA);
        n = 0;
        while (!owrite_req && n < 20) begin
            @(negedge iclk);
            n++;
        end
        @(posedge iclk); #2 spur_r = 1;
        @(posedge iclk); #2 spur_r = 0;
        @(negedge iclk);
        chk("t6_no_rd_valid", 64'(ord_data_valid), 0);
        chk("t6_level_kept", 64'(ofifo_level), 1);
        chk("t6_req_kept", 64'(owrite_req), 1);
        auto_en = 1;
        settle();
        @(posedge iclk); #2 spur_w = 1;
        @(posedge iclk); #2 spur_w = 0;
        @(negedge iclk);
        chk("t6_idle_level", 64'(ofifo_level), 0);
        chk("t6_idle_no_req", 64'(owrite_req), 0);

        // read-after-write to the top address, write granted last beforehand
        wr(22'h100, 16'h1234);
        settle();
        @(negedge iclk);
        chk("t4_both_ready", {62'd0, owr_ready, ord_ready}, 3);
        iwr_valid = 1; iwr_address = 22'h3FFFFF; iwr_data = 16'hBEEF;
        ird_valid = 1; ird_address = 22'h3FFFFF;
        @(negedge iclk);
        iwr_valid = 0; ird_valid = 0;
        n = 0;
        while (!ord_data_valid && n < 50) begin
            @(negedge iclk);
            n++;
        end
        chk("t4_valid_seen", 64'(ord_data_valid), 1);
`ifdef SDRAM_RAW_ORDER_EN
        chk("t4_data", 64'(ord_data), 64'h0BEEF);
`else
        chk("t4_data_stale", 64'(ord_data), 0);
`endif
        @(negedge iclk);
        chk("t4_pulse_one_cycle", 64'(ord_data_valid), 0);
        settle();

        // both kinds pending: grants alternate starting with a write
        ireset_n = 0;
        @(negedge iclk);
        ireset_n = 1;
        grants.delete();
        auto_en = 0;
        wr(22'd1, 16'd1);
        fork
            begin
                wr(22'd2, 16'd2);
                wr(22'd3, 16'd3);
                wr(22'd4, 16'd4);
            end
            rd(22'h10);
        join
        auto_en = 1;
        rd(22'h11);
        n = 0;
        while (grants.size() < 4 && n < 200) begin
            @(negedge iclk);
            n++;
        end
        chk("t5_grant_count", 64'(grants.size() >= 4), 1);
`ifndef SDRAM_RAW_ORDER_EN
        if (grants.size() >= 4) begin
            chk("t5_g0", 64'(grants[0]), 1);
            chk("t5_g1", 64'(grants[1]), 2);
            chk("t5_g2", 64'(grants[2]), 1);
            chk("t5_g3", 64'(grants[3]), 2);
        end
`endif
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
